// File: rtl/vdp_vram_arbiter.sv
// VRAM port arbiter: display fetch has absolute priority (plus one guard cycle),
// CPU writes are queued in a small FIFO and CPU reads wait until that FIFO has drained.
module vdp_vram_arbiter #(
    parameter int ADDR_W     = 14,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_L,
    input  logic              disp_go,
    input  logic [ADDR_W-1:0] disp_addr,
    input  logic              cpu_wr_req,
    input  logic [ADDR_W-1:0] cpu_wr_addr,
    input  logic [7:0]        cpu_wr_data,
    output logic              cpu_wr_full,
    input  logic              cpu_rd_req,
    input  logic [ADDR_W-1:0] cpu_rd_addr,
    output logic [7:0]        cpu_rd_data,
    output logic              cpu_rd_valid,
    output logic              cpu_busy,
    output logic [ADDR_W-1:0] vram_addr,
    output logic [7:0]        vram_wdata,
    output logic              vram_we,
    input  logic [7:0]        vram_rdata,
    output logic              disp_owns,
    output logic              wr_overflow,
    output logic              dbgState
);
    // Handshake: cpu_wr_req is a push strobe accepted whenever cpu_wr_full is low
    // (or a pop happens the same cycle); cpu_rd_valid is a one-cycle strobe, no back-pressure.

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    typedef enum logic {
        IDLE    = 1'b0,
        RD_WAIT = 1'b1
    } state_t;

    state_t            state, stateNext;
    logic              guard;
    logic [ADDR_W-1:0] fifoAddr [FIFO_DEPTH];
    logic [7:0]        fifoData [FIFO_DEPTH];
    logic [PTR_W-1:0]  wrPtr, rdPtr;
    logic [CNT_W-1:0]  count;
    logic              rdPending;
    logic [ADDR_W-1:0] rdAddrQ;
    logic [7:0]        rdDataQ;
    logic              push, pop, rdDone, fifoEmpty, fifoFull;

    assign disp_owns   = disp_go | guard;
    assign fifoEmpty   = (count == '0);
    assign fifoFull    = (count == CNT_W'(FIFO_DEPTH));
    assign cpu_wr_full = fifoFull;
    // A push into a full FIFO is still accepted when the head is popped in the same cycle.
    assign push        = cpu_wr_req & (~fifoFull | pop);
    assign cpu_busy    = rdPending | ~fifoEmpty | (state == RD_WAIT);
    assign dbgState    = (state == RD_WAIT);

    // Read data bypasses straight from VRAM on the completion cycle, then is held.
    assign cpu_rd_valid = rdDone;
    assign cpu_rd_data  = rdDone ? vram_rdata : rdDataQ;

    always_ff @(posedge clk or negedge rst_L) begin
        if (!rst_L) begin
            state <= IDLE;
            guard <= 1'b0;
        end else begin
            state <= stateNext;
            guard <= disp_go;
        end
    end

    always_comb begin
        stateNext  = state;
        pop        = 1'b0;
        rdDone     = 1'b0;
        vram_addr  = disp_addr;
        vram_wdata = '0;
        vram_we    = 1'b0;
        case (state)
            IDLE: begin
                if (!disp_owns) begin
                    if (!fifoEmpty) begin
                        pop        = 1'b1;
                        vram_addr  = fifoAddr[rdPtr];
                        vram_wdata = fifoData[rdPtr];
                        vram_we    = 1'b1;
                    end else if (rdPending) begin
                        vram_addr = rdAddrQ;
                        stateNext = RD_WAIT;
                    end
                end
            end
            // Data for the read issued last cycle arrives regardless of display ownership.
            RD_WAIT: begin
                rdDone    = 1'b1;
                stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifoAddr[wrPtr] <= cpu_wr_addr;
            fifoData[wrPtr] <= cpu_wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_L) begin
        if (!rst_L) begin
            wrPtr       <= '0;
            rdPtr       <= '0;
            count       <= '0;
            wr_overflow <= 1'b0;
        end else begin
            if (push) wrPtr <= wrPtr + 1'b1;
            if (pop)  rdPtr <= rdPtr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (cpu_wr_req && fifoFull && !pop) wr_overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_L) begin
        if (!rst_L) begin
            rdPending <= 1'b0;
            rdAddrQ   <= '0;
            rdDataQ   <= '0;
        end else begin
            if (cpu_rd_req) begin
                rdPending <= 1'b1;
                rdAddrQ   <= cpu_rd_addr;
            end else if (rdDone) begin
                rdPending <= 1'b0;
            end
            if (rdDone) rdDataQ <= vram_rdata;
        end
    end

endmodule

// File: tb/tb_vdp_vram_arbiter.sv
// Self-checking bench for vdp_vram_arbiter: directed scenarios plus a random phase,
// with a VRAM model and write/read scoreboards.
module tb_vdp_vram_arbiter;
    localparam int ADDR_W = 14;
    localparam int DEPTH  = 4;

    logic              clk = 1'b0;
    logic              rst_L = 1'b0;
    logic              disp_go = 1'b0;
    logic [ADDR_W-1:0] disp_addr = '0;
    logic              cpu_wr_req = 1'b0;
    logic [ADDR_W-1:0] cpu_wr_addr = '0;
    logic [7:0]        cpu_wr_data = '0;
    logic              cpu_wr_full;
    logic              cpu_rd_req = 1'b0;
    logic [ADDR_W-1:0] cpu_rd_addr = '0;
    logic [7:0]        cpu_rd_data;
    logic              cpu_rd_valid;
    logic              cpu_busy;
    logic [ADDR_W-1:0] vram_addr;
    logic [7:0]        vram_wdata;
    logic              vram_we;
    logic [7:0]        vram_rdata = '0;
    logic              disp_owns;
    logic              wr_overflow;
    logic              dbgState;

    logic [7:0]          vmem   [1 << ADDR_W];
    logic [7:0]          shadow [1 << ADDR_W];
    bit                  written [32];
    logic [ADDR_W+7:0]   exp_wr_q [$];
    logic [7:0]          exp_rd_q [$];
    logic [ADDR_W+7:0]   monW;
    logic [7:0]          monR;
    logic                prevGo;
    int                  checks = 0;
    int                  failures = 0;
    int                  lat;

    always #5 clk = ~clk;

    vdp_vram_arbiter #(.ADDR_W(ADDR_W), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_L(rst_L), .disp_go(disp_go), .disp_addr(disp_addr),
        .cpu_wr_req(cpu_wr_req), .cpu_wr_addr(cpu_wr_addr), .cpu_wr_data(cpu_wr_data),
        .cpu_wr_full(cpu_wr_full), .cpu_rd_req(cpu_rd_req), .cpu_rd_addr(cpu_rd_addr),
        .cpu_rd_data(cpu_rd_data), .cpu_rd_valid(cpu_rd_valid), .cpu_busy(cpu_busy),
        .vram_addr(vram_addr), .vram_wdata(vram_wdata), .vram_we(vram_we),
        .vram_rdata(vram_rdata), .disp_owns(disp_owns), .wr_overflow(wr_overflow),
        .dbgState(dbgState)
    );

    // Synchronous VRAM: data for an address appears the cycle after it is presented.
    always @(posedge clk) begin
        if (vram_we) vmem[vram_addr] <= vram_wdata;
        vram_rdata <= vmem[vram_addr];
    end

    always @(posedge clk or negedge rst_L) begin
        if (!rst_L) prevGo <= 1'b0;
        else        prevGo <= disp_go;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s obs=0x%0h exp=0x%0h t=%0t", tag, obs, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst_L) begin
            chk("disp_owns", 32'(disp_owns), 32'(disp_go | prevGo));
            if (disp_go | prevGo) begin
                chk("own_we", 32'(vram_we), 0);
                chk("own_addr", 32'(vram_addr), 32'(disp_addr));
            end
            if (vram_we) begin
                if (exp_wr_q.size() == 0) chk("wr_unexpected", 1, 0);
                else begin
                    monW = exp_wr_q.pop_front();
                    chk("wr_order", 32'({vram_addr, vram_wdata}), 32'(monW));
                end
            end
            if (cpu_rd_valid) begin
                if (exp_rd_q.size() == 0) chk("rd_unexpected", 1, 0);
                else begin
                    monR = exp_rd_q.pop_front();
                    chk("rd_data", 32'(cpu_rd_data), 32'(monR));
                end
            end
        end
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic pushWr(input logic [ADDR_W-1:0] a, input logic [7:0] d, input bit drop);
        cpu_wr_req  = 1'b1;
        cpu_wr_addr = a;
        cpu_wr_data = d;
        if (!drop) begin
            exp_wr_q.push_back({a, d});
            shadow[a] = d;
            if (a < 32) written[a[4:0]] = 1'b1;
        end
    endtask

    task automatic readReq(input logic [ADDR_W-1:0] a);
        cpu_rd_req  = 1'b1;
        cpu_rd_addr = a;
        exp_rd_q.push_back(shadow[a]);
    endtask

    task automatic waitRd(output int n);
        n = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (cpu_rd_valid) begin
                n = i;
                break;
            end
        end
        if (n == 0) chk("rd_timeout", 1, 0);
    endtask

    task automatic chkZero(input string p);
        chk({p, "_rd_data"}, 32'(cpu_rd_data), 0);
        chk({p, "_vram_addr"}, 32'(vram_addr), 0);
        chk({p, "_vram_we"}, 32'(vram_we), 0);
        chk({p, "_rd_valid"}, 32'(cpu_rd_valid), 0);
        chk({p, "_overflow"}, 32'(wr_overflow), 0);
        chk({p, "_busy"}, 32'(cpu_busy), 0);
        chk({p, "_owns"}, 32'(disp_owns), 0);
        chk({p, "_full"}, 32'(cpu_wr_full), 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        #3;
        chkZero("rst");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_L = 1'b1;

        // T2: idle write reaches VRAM the cycle after the push
        cycle(); pushWr(14'h3F00, 8'hA5, 1'b0);
        cycle(); cpu_wr_req = 1'b0;
        @(negedge clk);
        chk("t2_we", 32'(vram_we), 1);
        chk("t2_addr", 32'(vram_addr), 32'h3F00);
        chk("t2_data", 32'(vram_wdata), 32'hA5);

        // T3: display priority with guard cycle
        cycle(); disp_go = 1'b1; disp_addr = 14'h1234; pushWr(14'h0100, 8'h01, 1'b0);
        @(negedge clk); chk("t3_we_go1", 32'(vram_we), 0);
        cycle(); pushWr(14'h0101, 8'h02, 1'b0);
        @(negedge clk); chk("t3_we_go2", 32'(vram_we), 0);
        cycle(); disp_go = 1'b0; cpu_wr_req = 1'b0;
        @(negedge clk); chk("t3_we_guard", 32'(vram_we), 0); chk("t3_owns_guard", 32'(disp_owns), 1);
        cycle();
        @(negedge clk); chk("t3_we_a", 32'(vram_we), 1); chk("t3_addr_a", 32'(vram_addr), 32'h0100);
        cycle();
        @(negedge clk); chk("t3_we_b", 32'(vram_we), 1); chk("t3_addr_b", 32'(vram_addr), 32'h0101);

        // T4: read-after-write ordering
        cycle(); pushWr(14'h0010, 8'h11, 1'b0);
        cycle(); cpu_wr_req = 1'b0; readReq(14'h0010);
        @(negedge clk); chk("t4_wr_first", 32'(vram_we), 1); chk("t4_wr_addr", 32'(vram_addr), 32'h0010);
        cycle(); cpu_rd_req = 1'b0;
        waitRd(lat);
        chk("t4_latency", 32'(lat), 2);
        chk("t4_data", 32'(cpu_rd_data), 32'h11);

        // T5: full FIFO under display ownership, fifth push dropped
        cycle(); disp_go = 1'b1; disp_addr = 14'h0555;
        for (int i = 0; i < 5; i++) begin
            pushWr(14'h0200 + 14'(i), 8'hC0 + 8'(i), i == 4);
            cycle();
            @(negedge clk);
            if (i == 2) chk("t5_not_full", 32'(cpu_wr_full), 0);
            if (i == 3) begin chk("t5_full", 32'(cpu_wr_full), 1); chk("t5_no_ovf", 32'(wr_overflow), 0); end
            if (i == 4) chk("t5_ovf", 32'(wr_overflow), 1);
        end
        cycle(); cpu_wr_req = 1'b0; disp_go = 1'b0;
        repeat (8) cycle();
        chk("t5_drained", 32'(exp_wr_q.size()), 0);
        chk("t5_ovf_sticky", 32'(wr_overflow), 1);
        chk("t5_full_clr", 32'(cpu_wr_full), 0);

        // T6: display grabs the port during the read-wait cycle
        cycle(); readReq(14'h3F00);
        cycle(); cpu_rd_req = 1'b0;
        cycle(); disp_go = 1'b1; disp_addr = 14'h2222;
        @(negedge clk);
        chk("t6_valid", 32'(cpu_rd_valid), 1);
        chk("t6_data", 32'(cpu_rd_data), 32'hA5);
        chk("t6_addr", 32'(vram_addr), 32'h2222);
        cycle(); disp_go = 1'b0;
        repeat (2) cycle();
        chk("t6_hold", 32'(cpu_rd_data), 32'hA5);

        // Random traffic over a small address window
        for (int k = 0; k < 300; k++) begin
            logic [ADDR_W-1:0] a;
            cycle();
            cpu_wr_req = 1'b0;
            cpu_rd_req = 1'b0;
            disp_go    = ($urandom_range(0, 9) < 3);
            disp_addr  = 14'($urandom_range(0, 16383));
            a          = 14'($urandom_range(0, 31));
            if (exp_rd_q.size() == 0) begin
                if ($urandom_range(0, 9) == 0) begin
                    if (written[a[4:0]]) readReq(a);
                end else if (exp_wr_q.size() < DEPTH && $urandom_range(0, 9) < 5) begin
                    pushWr(a, 8'($urandom_range(0, 255)), 1'b0);
                end
            end
        end
        cycle(); cpu_wr_req = 1'b0; cpu_rd_req = 1'b0; disp_go = 1'b0;
        for (int k = 0; k < 100; k++) begin
            if (exp_wr_q.size() == 0 && exp_rd_q.size() == 0) break;
            cycle();
        end
        chk("rand_wr_left", 32'(exp_wr_q.size()), 0);
        chk("rand_rd_left", 32'(exp_rd_q.size()), 0);

        // T1: reset in the middle of queued work
        cycle(); disp_go = 1'b1; disp_addr = 14'h0777; pushWr(14'h0020, 8'h31, 1'b0);
        cycle(); pushWr(14'h0021, 8'h32, 1'b0);
        cycle(); pushWr(14'h0022, 8'h33, 1'b0);
        cycle(); cpu_wr_req = 1'b0; readReq(14'h0020);
        cycle(); cpu_rd_req = 1'b0;
        @(negedge clk);
        chk("t1_busy_pre", 32'(cpu_busy), 1);
        #2;
        rst_L = 1'b0; disp_go = 1'b0; disp_addr = '0;
        exp_wr_q.delete();
        exp_rd_q.delete();
        #1;
        chkZero("t1");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_L = 1'b1;
        repeat (10) cycle();
        chk("t1_idle_busy", 32'(cpu_busy), 0);
        chk("t1_idle_we", 32'(vram_we), 0);
        pushWr(14'h0030, 8'h77, 1'b0);
        cycle(); cpu_wr_req = 1'b0;
        @(negedge clk);
        chk("t1_new_we", 32'(vram_we), 1);
        chk("t1_new_data", 32'(vram_wdata), 32'h77);
        repeat (3) cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
